// File: rtl/regfile_32x64.sv
`timescale 1ns/10ps
// -----------------------------------------------------------------------------
// mux32_1 -- single-bit 32:1 selector (library cell model).
//   in_i   [31:0]  candidate bits, one per register index
//   sel_i  [4:0]   register index
//   out_o          selected bit
// -----------------------------------------------------------------------------
module mux32_1 (
  input  logic [31:0] in_i,
  input  logic [4:0]  sel_i,
  output logic        out_o
);
  assign out_o = in_i[sel_i];
endmodule

// -----------------------------------------------------------------------------
// regfile_32x64 -- 32 x WIDTH general-purpose register file.
//   One synchronous write port, two combinational read ports. Index 31 is the
//   zero register: it reads 0 and ignores writes. With BYPASS=1 a write in
//   flight is forwarded to any read port addressing the same register.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (clears registers 0-30)
//   write_enable  commit write_data to write_addr at the next rising edge
//   write_addr    [4:0]       destination register index
//   write_data    [WIDTH-1:0] data to write
//   read_addr_1   [4:0]       port-1 register index
//   read_addr_2   [4:0]       port-2 register index
//   read_data_1   [WIDTH-1:0] contents of register read_addr_1
//   read_data_2   [WIDTH-1:0] contents of register read_addr_2
// -----------------------------------------------------------------------------
module regfile_32x64 #(
  parameter int WIDTH  = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [4:0]       write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [4:0]       read_addr_1,
  input  logic [4:0]       read_addr_2,
  output logic [WIDTH-1:0] read_data_1,
  output logic [WIDTH-1:0] read_data_2
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic [WIDTH-1:0] regs_q [31];
  logic [WIDTH-1:0] regs_d [31];
  logic [31:0]      wr_dec;
  logic [31:0]      slice  [WIDTH];
  logic [WIDTH-1:0] mux_1;
  logic [WIDTH-1:0] mux_2;
  logic             hit_1;
  logic             hit_2;

  // One-hot write decoder. The address is only looked at when write_enable is
  // high, so an unknown idle address can never select a register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_dec = '0;
    if (write_enable) begin
      wr_dec[write_addr] = 1'b1;
    end
    wr_dec[31] = 1'b0;
  end

  always_comb begin
    for (int n = 0; n < 31; n++) begin
      regs_d[n] = wr_dec[n] ? write_data : regs_q[n];
    end
  end

  // NOTE: this array is reset on purpose -- the architecture requires every
  // register to read 0 out of reset; large RAM-style arrays normally are not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < 31; n++) begin
        // NOTE: sequential state is always updated with non-blocking assignments.
        regs_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 31; n++) begin
        regs_q[n] <= regs_d[n];
      end
    end
  end

  // Transpose storage into per-bit slices; index 31 is tied to 0 (XZR).
  always_comb begin
    for (int b = 0; b < WIDTH; b++) begin
      slice[b] = '0;
      for (int n = 0; n < 31; n++) begin
        slice[b][n] = regs_q[n][b];
      end
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    mux32_1 u_mux_1 (.in_i(slice[b]), .sel_i(read_addr_1), .out_o(mux_1[b]));
    mux32_1 u_mux_2 (.in_i(slice[b]), .sel_i(read_addr_2), .out_o(mux_2[b]));
  end

  // Forwarding never applies to the zero register, and is suppressed during
  // reset so the outputs stay 0 while writes are being ignored.
  assign hit_1 = BYPASS && reset && write_enable &&
                 (write_addr == read_addr_1) && (write_addr != ZERO_REG);
  assign hit_2 = BYPASS && reset && write_enable &&
                 (write_addr == read_addr_2) && (write_addr != ZERO_REG);

  assign read_data_1 = hit_1 ? write_data : mux_1;
  assign read_data_2 = hit_2 ? write_data : mux_2;

endmodule

// File: tb/tb_regfile_32x64.sv
`timescale 1ns/10ps
// -----------------------------------------------------------------------------
// tb_regfile_32x64 -- scoreboard bench for regfile_32x64.
//   Two instances share all inputs: one with BYPASS=0, one with BYPASS=1.
//   Stimulus pushes expected read values into a queue; a monitor process pops
//   and compares them against the live read ports.
// -----------------------------------------------------------------------------
module tb_regfile_32x64;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

  regfile_32x64 #(.WIDTH(64), .BYPASS(1'b0)) u_dut_b0 (
    .clk(clk), .reset(reset), .write_enable(we), .write_addr(wa),
    .write_data(wd), .read_addr_1(ra1), .read_addr_2(ra2),
    .read_data_1(rd1_b0), .read_data_2(rd2_b0)
  );

  regfile_32x64 #(.WIDTH(64), .BYPASS(1'b1)) u_dut_b1 (
    .clk(clk), .reset(reset), .write_enable(we), .write_addr(wa),
    .write_data(wd), .read_addr_1(ra1), .read_addr_2(ra2),
    .read_data_1(rd1_b1), .read_data_2(rd2_b1)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  typedef struct {
    string       name;
    int          sel;   // 0: b0 port1, 1: b0 port2, 2: b1 port1, 3: b1 port2
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_CAFE_F00D;

  function automatic logic [63:0] pat(int n);
    return 64'h0101_0101_0101_0101 * 64'(n);
  endfunction

  function automatic logic [63:0] actual(int sel);
    case (sel)
      0:       return rd1_b0;
      1:       return rd2_b0;
      2:       return rd1_b1;
      default: return rd2_b1;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares every queued expectation against the current outputs.
  initial begin
    exp_t e;
    forever begin
      #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0s]", e.name,
              (e.sel == 0) ? "b0.rd1" : (e.sel == 1) ? "b0.rd2" :
              (e.sel == 2) ? "b1.rd1" : "b1.rd2"), actual(e.sel), e.exp);
      end
    end
  end

  // Wait for the monitor to consume everything; a stall counts as a failure.
  task automatic drain(string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: monitor left %0d entries, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Let the read muxes settle, then queue expectations for all four ports.
  task automatic expect_rd(string name, logic [63:0] p1_b0, logic [63:0] p2_b0,
                           logic [63:0] p1_b1, logic [63:0] p2_b1);
    #5;
    exp_q.push_back('{name, 0, p1_b0});
    exp_q.push_back('{name, 1, p2_b0});
    exp_q.push_back('{name, 2, p1_b1});
    exp_q.push_back('{name, 3, p2_b1});
    drain(name);
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    expect_rd("reset_state", 64'd0, 64'd0, 64'd0, 64'd0);
    @(negedge clk) reset = 1'b1;

    // Preload X5, then pull reset mid-cycle: clears with no clock edge.
    @(negedge clk); we = 1'b1; wa = 5'd5; wd = DEAD; ra1 = 5'd5; ra2 = 5'd0;
    @(negedge clk); we = 1'b0;
    expect_rd("x5_preload", DEAD, 64'd0, DEAD, 64'd0);
    reset = 1'b0;
    expect_rd("reset_async", 64'd0, 64'd0, 64'd0, 64'd0);

    // Writes during reset are ignored and never forwarded.
    we = 1'b1; wa = 5'd5; wd = '1;
    expect_rd("write_in_reset", 64'd0, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    expect_rd("after_release", 64'd0, 64'd0, 64'd0, 64'd0);

    // Write sweep over X0..X30, then read pairs (n, 30-n).
    for (int n = 0; n < 31; n++) begin
      @(negedge clk); we = 1'b1; wa = 5'(n); wd = pat(n);
    end
    @(negedge clk); we = 1'b0;
    for (int n = 0; n < 31; n++) begin
      @(negedge clk); ra1 = 5'(n); ra2 = 5'(30 - n);
      expect_rd($sformatf("sweep_%0d", n), pat(n), pat(30 - n), pat(n), pat(30 - n));
    end

    // Zero register: write of all ones to X31 is neither stored nor forwarded.
    @(negedge clk); we = 1'b1; wa = 5'd31; wd = '1; ra1 = 5'd31; ra2 = 5'd31;
    expect_rd("xzr_pre_edge", 64'd0, 64'd0, 64'd0, 64'd0);
    @(negedge clk); we = 1'b0;
    expect_rd("xzr_post_edge", 64'd0, 64'd0, 64'd0, 64'd0);

    // Same-cycle bypass on both ports.
    @(negedge clk); we = 1'b1; wa = 5'd7; wd = 64'h1111; ra1 = 5'd0; ra2 = 5'd0;
    @(negedge clk); wd = 64'h2222; ra1 = 5'd7; ra2 = 5'd7;
    expect_rd("bypass_pre_edge", 64'h1111, 64'h1111, 64'h2222, 64'h2222);
    @(negedge clk); we = 1'b0;
    expect_rd("bypass_post_edge", 64'h2222, 64'h2222, 64'h2222, 64'h2222);

    // Ports forward independently: only port 1 matches the write address.
    @(negedge clk); we = 1'b1; wa = 5'd7; wd = 64'h3333; ra1 = 5'd7; ra2 = 5'd10;
    expect_rd("bypass_port1_only", 64'h2222, pat(10), 64'h3333, pat(10));

    // Write-enable gating: idle address/data over four edges change nothing.
    @(negedge clk); we = 1'b1; wa = 5'd3; wd = 64'hAAAA; ra1 = 5'd3;
    @(negedge clk); we = 1'b0; wa = 5'd3; wd = 64'h5555;
    repeat (4) @(negedge clk);
    expect_rd("we_gating", 64'hAAAA, pat(10), 64'hAAAA, pat(10));
    wa = 'x;
    @(negedge clk);
    expect_rd("x_addr_idle", 64'hAAAA, pat(10), 64'hAAAA, pat(10));

    // Back-to-back writes to X10 watched on port 2.
    @(negedge clk); we = 1'b1; wa = 5'd10; wd = 64'd1; ra2 = 5'd10;
    expect_rd("b2b_w1", 64'hAAAA, pat(10), 64'hAAAA, 64'd1);
    @(negedge clk); wd = 64'd2;
    expect_rd("b2b_w2", 64'hAAAA, 64'd1, 64'hAAAA, 64'd2);
    @(negedge clk); wd = 64'd3;
    expect_rd("b2b_w3", 64'hAAAA, 64'd2, 64'hAAAA, 64'd3);
    @(negedge clk); we = 1'b0;
    expect_rd("b2b_final", 64'hAAAA, 64'd3, 64'hAAAA, 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
